btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 138 +++++++++++++
 tb/tb_btn_debounce.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Two-channel push-button debouncer with press, release and long-press strobes.
// Each channel has its own synchronizer, state machine and counters.
module btn_debounce #(
  parameter int DB_CYCLES   = 1000000,
  parameter int LONG_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_in,
  output logic [1:0] btn_out,
  output logic [1:0] press_pulse,
  output logic [1:0] release_pulse,
  output logic [1:0] long_pulse,
  output logic [3:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  genvar ch;
  generate
    for (ch = 0; ch < 2; ch++) begin : g_ch
      logic             sync1, sync2;
      state_t           state, state_nx;
      logic [CNT_W-1:0] db_cnt, db_cnt_nx;
      logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
      logic             long_done, long_done_nx;
      logic             out_q, out_nx;
      logic             press_q, press_nx;
      logic             release_q, release_nx;
      logic             long_q, long_nx;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1     <= 1'b1;
          sync2     <= 1'b1;
          state     <= IDLE;
          db_cnt    <= '0;
          hold_cnt  <= '0;
          long_done <= 1'b0;
          out_q     <= 1'b1;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          long_q    <= 1'b0;
        end else begin
          sync1     <= btn_in[ch];
          sync2     <= sync1;
          state     <= state_nx;
          db_cnt    <= db_cnt_nx;
          hold_cnt  <= hold_cnt_nx;
          long_done <= long_done_nx;
          out_q     <= out_nx;
          press_q   <= press_nx;
          release_q <= release_nx;
          long_q    <= long_nx;
        end
      end

      always_comb begin
        state_nx     = state;
        db_cnt_nx    = db_cnt;
        hold_cnt_nx  = hold_cnt;
        long_done_nx = long_done;
        out_nx       = out_q;
        press_nx     = 1'b0;
        release_nx   = 1'b0;
        long_nx      = 1'b0;
        case (state)
          IDLE: begin
            if (!sync2) begin
              state_nx  = PRESS_CHK;
              db_cnt_nx = '0;
            end
          end
          PRESS_CHK: begin
            if (sync2) begin
              state_nx  = IDLE;
              db_cnt_nx = '0;
            end else if (db_cnt == DB_LAST) begin
              state_nx     = HELD;
              out_nx       = 1'b0;
              press_nx     = 1'b1;
              hold_cnt_nx  = '0;
              long_done_nx = 1'b0;
            end else begin
              db_cnt_nx = db_cnt + CNT_ONE;
            end
          end
          HELD: begin
            if (sync2) begin
              state_nx  = RELEASE_CHK;
              db_cnt_nx = '0;
            end else begin
              if (hold_cnt != LONG_MAX) hold_cnt_nx = hold_cnt + CNT_ONE;
              // long_done keeps the strobe to one per accepted press
              if (hold_cnt == LONG_LAST && !long_done) begin
                long_nx      = 1'b1;
                long_done_nx = 1'b1;
              end
            end
          end
          RELEASE_CHK: begin
            // A bounce back low resumes the hold with hold_cnt frozen
            if (!sync2) begin
              state_nx = HELD;
            end else if (db_cnt == DB_LAST) begin
              state_nx     = IDLE;
              out_nx       = 1'b1;
              release_nx   = 1'b1;
              hold_cnt_nx  = '0;
              long_done_nx = 1'b0;
            end else begin
              db_cnt_nx = db_cnt + CNT_ONE;
            end
          end
          default: state_nx = IDLE;
        endcase
      end

      assign btn_out[ch]          = out_q;
      assign press_pulse[ch]      = press_q;
      assign release_pulse[ch]    = release_q;
      assign long_pulse[ch]       = long_q;
      assign dbg_state[2*ch +: 2] = state;
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DB_CYCLES=4, LONG_CYCLES=20.
// Per-cycle vector table plus hand sequences for long-press timing and reset.
module tb_btn_debounce;

  logic       clk;
  logic       reset;
  logic [1:0] btn_in;
  logic [1:0] btn_out, press_pulse, release_pulse, long_pulse;
  logic [3:0] dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] in;
    logic [1:0] out;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lg;
  } vec_t;

  vec_t vecs[$];

  btn_debounce #(.DB_CYCLES(4), .LONG_CYCLES(20), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_out(btn_out),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input logic rst, input logic [1:0] in,
                              input logic [1:0] out, input logic [1:0] pr,
                              input logic [1:0] rl, input logic [1:0] lg, input int n);
    vec_t v;
    v.name = nm; v.rst = rst; v.in = in; v.out = out; v.pr = pr; v.rl = rl; v.lg = lg;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic step(input logic rst, input logic [1:0] in);
    reset  = rst;
    btn_in = in;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int longs;
    reset  = 1'b1;
    btn_in = 2'b11;

    // Reset with both pins low, then both presses accepted on edge 7
    add("rst",       1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2);
    add("pre",       0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 6);
    add("acc",       0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1);
    add("held",      0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3);
    add("rel_pre",   0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 6);
    add("rel_acc",   0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 1);
    add("idle",      0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2);
    // Three-cycle low glitch on channel 0 is rejected
    add("glitch_lo", 0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 3);
    add("glitch_hi", 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 8);
    // Channel 0 pressed, channel 1 two cycles later; long strobes 20 edges after each press
    add("stag_a",    0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2);
    add("stag_b",    0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 4);
    add("p0",        0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 1);
    add("p0h",       0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1);
    add("p1",        0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1);
    add("hold",      0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 17);
    add("long0",     0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1);
    add("hold2",     0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add("long1",     0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1);
    add("hold3",     0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 11);
    // One-cycle high glitch while held; no release and no second long strobe
    add("held_gl",   0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add("held_aft",  0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8);
    // Release channel 0 only
    add("r0",        0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 6);
    add("r0_acc",    0, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 1);
    add("r0_idle",   0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2);
    // Release channel 1, re-press it, reset at db_cnt=2, then full re-qualification
    add("r1",        0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 6);
    add("r1_acc",    0, 2'b11, 2'b11, 2'b00, 2'b10, 2'b00, 1);
    add("p1_chk",    0, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 5);
    add("abort",     1, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2);
    add("requal",    0, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 6);
    add("re_acc",    0, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 1);
    add("re_held",   0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].in);
      check($sformatf("%s[%0d] btn_out", vecs[i].name, i), {2'b00, btn_out}, {2'b00, vecs[i].out});
      check($sformatf("%s[%0d] press", vecs[i].name, i), {2'b00, press_pulse}, {2'b00, vecs[i].pr});
      check($sformatf("%s[%0d] release", vecs[i].name, i), {2'b00, release_pulse}, {2'b00, vecs[i].rl});
      check($sformatf("%s[%0d] long", vecs[i].name, i), {2'b00, long_pulse}, {2'b00, vecs[i].lg});
    end

    // Channel 1 was accepted 2 edges ago: its long strobe is due 18 edges from here
    k = 0;
    while (k < 30 && long_pulse[1] !== 1'b1) begin
      step(1'b0, 2'b01);
      k++;
    end
    check("long1_latency", 4'(k), 4'(18));
    check("long1_ch0_quiet", {2'b00, long_pulse}, 4'b0010);
    longs = 0;
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 2'b01);
      if (long_pulse[1] === 1'b1) longs++;
    end
    check("long1_once", 4'(longs), 4'd0);
    check("long1_still_held", {2'b00, btn_out}, 4'b0001);

    // Reset mid-hold aborts with no strobes and restores idle state
    step(1'b1, 2'b11);
    check("rst_hold_out", {2'b00, btn_out}, 4'b0011);
    check("rst_hold_strobes", {press_pulse, release_pulse | long_pulse}, 4'b0000);
    check("rst_hold_state", dbg_state, 4'b0000);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b11);
      if ((press_pulse | release_pulse | long_pulse) !== 2'b00) k++;
    end
    check("post_rst_no_strobe", 4'(k), 4'd0);
    check("post_rst_out", {2'b00, btn_out}, 4'b0011);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
